// File: rtl/sys_defs_pkg.sv
// Shared memory-interface types and drain-side constants used by the
// output writer, the memory controller and the testbench.
package sys_defs_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    localparam int  MEM_BLOCKS_PER_VECTOR = 4;
    localparam ADDR O_BASE                = 32'h0000_2000;

    typedef logic [MEM_BLOCKS_PER_VECTOR*64-1:0] O_VECTOR_T;

    typedef enum logic [1:0] {
        IDLE  = 2'h0,
        STORE = 2'h1,
        DONE  = 2'h2
    } DRAIN_STATE;

endpackage

// File: rtl/output_drain_writer.sv
// Drains KNN result vectors to memory as consecutive 64-bit stores and
// flags completion after a fixed number of vectors.
//
//   state | meaning
//   IDLE  | ready for the next result vector
//   STORE | issuing held block blk, retried until memory tags it
//   DONE  | all vectors stored; sticky until rst
module output_drain_writer
    import sys_defs_pkg::*;
#(
    parameter ADDR         O_BASE       = sys_defs_pkg::O_BASE,
    parameter int unsigned VECTOR_BYTES = MEM_BLOCKS_PER_VECTOR * 8,
    parameter int unsigned BLOCKS       = MEM_BLOCKS_PER_VECTOR,
    parameter int unsigned NUM_VECTORS  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [BLOCKS*64-1:0]               in_vector,
    output logic                               in_ready,
    input  MEM_TAG                             mem2proc_transaction_tag,
    output MEM_COMMAND                         proc2mem_command,
    output ADDR                                proc2mem_addr,
    output MEM_BLOCK                           proc2mem_data,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vectors_written,
    output logic                               done
);

    localparam int VW = $clog2(NUM_VECTORS + 1);
    localparam int BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

    DRAIN_STATE           state, state_nxt;
    logic [BW-1:0]        blk, blk_nxt;
    logic [VW-1:0]        vec_idx, vec_idx_nxt;
    logic [BLOCKS*64-1:0] hold;
    logic                 capture;
    logic                 accepted;
    ADDR                  store_addr;

    assign accepted   = (mem2proc_transaction_tag != '0);
    // vec_idx only advances on a fully stored vector, so it doubles as the count
    assign store_addr = O_BASE + ADDR'(vec_idx) * VECTOR_BYTES + (ADDR'(blk) << 3);
    assign vectors_written = vec_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            blk     <= '0;
            vec_idx <= '0;
            hold    <= '0;
        end else begin
            state   <= state_nxt;
            blk     <= blk_nxt;
            vec_idx <= vec_idx_nxt;
            if (capture) begin
                hold <= in_vector;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        blk_nxt          = blk;
        vec_idx_nxt      = vec_idx;
        capture          = 1'b0;
        in_ready         = 1'b0;
        done             = 1'b0;
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    blk_nxt   = '0;
                    state_nxt = STORE;
                end
            end
            STORE: begin
                proc2mem_command = MEM_STORE;
                proc2mem_addr    = store_addr;
                proc2mem_data    = hold[blk*64 +: 64];
                if (accepted) begin
                    if (blk == BW'(BLOCKS - 1)) begin
                        blk_nxt     = '0;
                        vec_idx_nxt = vec_idx + 1'b1;
                        state_nxt   = (vec_idx == VW'(NUM_VECTORS - 1)) ? DONE : IDLE;
                    end else begin
                        blk_nxt = blk + 1'b1;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
